clk_half_period_calc: RTL

- Converts a requested output frequency in Hz into the half-period cycle count that the programmable clock generators load.
- Sits upstream of the team's uint_div long divider. It drives the divider's start/A/B inputs and consumes its RESULT, remainder and dbz outputs.
- Validates the request, sequences exactly one divide, applies rounding, and presents the result to the clock generator with a valid pulse.

---
 rtl/clk_half_period_calc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/clk_half_period_calc.sv
// Converts a requested frequency (Hz) into a half-period count of clk cycles by driving an external uint_div.
// Optional build macro CLK_CALC_ROUND_NEAREST_EN: round half up instead of truncating the quotient.
module clk_half_period_calc #(
  parameter int WIDTH    = 32,
  parameter int CLK_FREQ = 100000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_freq_hz,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_half_period,
  output logic             out_error,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_idle,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_result,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam logic [WIDTH-1:0] LP_CLK  = WIDTH'(CLK_FREQ);
  localparam logic [WIDTH-1:0] LP_HALF = LP_CLK >> 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_ROUND, S_ERR} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_freq;
  logic [WIDTH-1:0] r_q;
  logic             r_dbz;
  logic             r_div_start;
  logic             r_out_valid;
  logic             r_out_error;
  logic [WIDTH-1:0] r_half;
  logic [WIDTH-1:0] r_div_b;
  logic             w_accept, w_bad, w_launch, w_sample, w_finish, w_fail;
  logic [WIDTH-1:0] w_rounded;

`ifdef CLK_CALC_ROUND_NEAREST_EN
  logic [WIDTH-1:0] r_rem;

  // Compare at WIDTH+1 bits so doubling the remainder never overflows.
  function automatic logic [WIDTH-1:0] round_half_up(input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] rem,
                                                     input logic [WIDTH-1:0] b);
    logic [WIDTH:0] twice_rem;
    twice_rem = {rem, 1'b0};
    return (twice_rem >= {1'b0, b}) ? q + WIDTH'(1) : q;
  endfunction

  assign w_rounded = round_half_up(r_q, r_rem, r_div_b);
`else
  logic w_unused_rem;
  assign w_unused_rem = ^div_remainder;
  assign w_rounded    = r_q;
`endif

  assign req_ready = resetn && (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_bad     = (r_freq == '0) || (r_freq > LP_HALF);

  // Output decode: divider handshakes and result completion
  always_comb begin
    w_launch = (r_state == S_LAUNCH) && div_idle && !r_div_start;
    w_sample = (r_state == S_WAIT) && div_idle && !r_div_start;
    w_finish = (r_state == S_ROUND) || (r_state == S_ERR);
    w_fail   = (r_state == S_ERR) || ((r_state == S_ROUND) && r_dbz);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CHECK;
      S_CHECK:  w_next = w_bad ? S_ERR : S_LAUNCH;
      S_LAUNCH: if (w_launch) w_next = S_WAIT;
      S_WAIT:   if (w_sample) w_next = S_ROUND;
      S_ROUND:  w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_error <= 1'b0;
      r_half      <= '0;
      r_div_b     <= '0;
    end else begin
      r_div_start <= w_launch;
      r_out_valid <= w_finish;
      if (w_finish) begin
        r_out_error <= w_fail;
        r_half      <= w_fail ? '0 : w_rounded;
      end
      // freq <= CLK_FREQ/2 here, so the doubling cannot overflow
      if ((r_state == S_CHECK) && !w_bad) r_div_b <= r_freq << 1;
    end
  end

  // Datapath captures carry no reset; they are only read once qualified by the FSM.
  always_ff @(posedge clk) begin
    if (w_accept) r_freq <= req_freq_hz;
    if (w_sample) begin
      r_q   <= div_result;
      r_dbz <= div_dbz;
`ifdef CLK_CALC_ROUND_NEAREST_EN
      r_rem <= div_remainder;
`endif
    end
  end

  assign div_start       = r_div_start;
  assign div_a           = LP_CLK;
  assign div_b           = r_div_b;
  assign out_valid       = r_out_valid;
  assign out_error       = r_out_error;
  assign out_half_period = r_half;

endmodule
